// File: rtl/seg_page_ctrl.sv
// Page scheduler for the 8-digit scan driver: selects one of three data pages or a
// timed one-shot message, and applies leading-zero blanking and selected-digit blink.
module seg_page_ctrl #(
    parameter int unsigned BLINK_HALF = 24_999_999,
    parameter int unsigned MSG_HOLD   = 99_999_999
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        page_next,
    input  logic [31:0] page0_data,
    input  logic [31:0] page1_data,
    input  logic [31:0] page2_data,
    input  logic        msg_req,
    input  logic [31:0] msg_data,
    input  logic        blink_en,
    input  logic [2:0]  blink_pos,
    input  logic        lz_blank,
    output logic [3:0]  bit_7,
    output logic [3:0]  bit_6,
    output logic [3:0]  bit_5,
    output logic [3:0]  bit_4,
    output logic [3:0]  bit_3,
    output logic [3:0]  bit_2,
    output logic [3:0]  bit_1,
    output logic [3:0]  bit_0,
    output logic [1:0]  page,
    output logic        msg_active
);

    localparam int unsigned HoldW  = (MSG_HOLD > 0) ? $clog2(MSG_HOLD + 1) : 1;
    localparam int unsigned BlinkW = (BLINK_HALF > 0) ? $clog2(BLINK_HALF + 1) : 1;

    localparam logic [3:0]  CodeBlank = 4'd10;
    localparam logic [31:0] AllBlank  = 32'hAAAA_AAAA;

    typedef enum logic [0:0] {
        StPage,
        StMsg
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          page_q, page_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [31:0]         msg_q, msg_d;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;
    logic                blink_clr;
    logic [31:0]         disp_q, disp_d;
    logic [31:0]         page_word;
    logic                lead;

    // Mode FSM: page advance, message latch/restart/abort and hold timing.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        hold_cnt_d = hold_cnt_q;
        msg_d      = msg_q;
        unique case (state_q)
            StPage: begin
                if (page_next) begin
                    page_d = (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;
                end
                if (msg_req) begin
                    state_d    = StMsg;
                    msg_d      = msg_data;
                    hold_cnt_d = '0;
                end
            end
            StMsg: begin
                // A new request outranks both the abort key and the hold expiry.
                if (msg_req) begin
                    msg_d      = msg_data;
                    hold_cnt_d = '0;
                end else if (page_next) begin
                    state_d    = StPage;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldW'(MSG_HOLD)) begin
                    state_d    = StPage;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            default: begin
                state_d = StPage;
            end
        endcase
    end

    // Restart the blink on any page change or message exit so the digit shows at once.
    assign blink_clr = (page_d != page_q) || ((state_q == StMsg) && (state_d == StPage));

    // Blink timer next state: free-running half-period counter with phase toggle on wrap.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (blink_clr) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BlinkW'(BLINK_HALF)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
        end
    end

    // Display composition: page word with blanking and blink, or the raw message word.
    always_comb begin
        case (page_q)
            2'd1:    page_word = page1_data;
            2'd2:    page_word = page2_data;
            default: page_word = page0_data;
        endcase
        lead = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (lz_blank && lead && (page_word[i*4 +: 4] == 4'd0)) begin
                page_word[i*4 +: 4] = CodeBlank;
            end else begin
                lead = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (blink_en && blink_ph_q && (blink_pos == 3'(i))) begin
                page_word[i*4 +: 4] = CodeBlank;
            end
        end
        disp_d = (state_q == StMsg) ? msg_q : page_word;
    end

    // State and output registers.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StPage;
            page_q      <= 2'd0;
            hold_cnt_q  <= '0;
            msg_q       <= AllBlank;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            disp_q      <= AllBlank;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            hold_cnt_q  <= hold_cnt_d;
            msg_q       <= msg_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            disp_q      <= disp_d;
        end
    end

    assign bit_7      = disp_q[31:28];
    assign bit_6      = disp_q[27:24];
    assign bit_5      = disp_q[23:20];
    assign bit_4      = disp_q[19:16];
    assign bit_3      = disp_q[15:12];
    assign bit_2      = disp_q[11:8];
    assign bit_1      = disp_q[7:4];
    assign bit_0      = disp_q[3:0];
    assign page       = page_q;
    assign msg_active = (state_q == StMsg);

endmodule
